// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 scan-code tracker: decodes E0/F0 prefixes into make/break
// events. It keeps a table of held keys so that typematic repeats are
// reported as repeats, and it exports press/held statistics.
module ps2_key_tracker #(
  parameter int unsigned MAX_KEYS = 4,
  parameter int unsigned CNT_W    = 8,
  localparam int unsigned HW      = $clog2(MAX_KEYS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [7:0]       code,
  input  logic             clear_count,
  output logic             evt_valid,
  output logic [8:0]       evt_code,
  output logic             evt_make,
  output logic             evt_repeat,
  output logic [HW-1:0]    held_count,
  output logic             any_held,
  output logic [8:0]       last_key,
  output logic [CNT_W-1:0] press_count,
  output logic             drop_err
);

  localparam int unsigned IW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t               state, state_nxt;
  logic                 dec_make, dec_brk, dec_ext;
  logic [8:0]           key;
  logic [MAX_KEYS-1:0]  valid;
  logic [8:0]           keys [MAX_KEYS];
  logic                 hit, free_ok;
  logic [IW-1:0]        hit_idx, free_idx;
  logic                 new_press, drop, brk_hit;
  logic [HW-1:0]        held_nxt;
  logic [CNT_W-1:0]     press_base, press_nxt;

  // Prefix state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Prefix decode: next state and make/break strobes
  always_comb begin
    state_nxt = state;
    dec_make  = 1'b0;
    dec_brk   = 1'b0;
    dec_ext   = 1'b0;
    if (code_valid) begin
      if (code == 8'h00 || code == 8'hFF) begin
        state_nxt = S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (code == 8'hE0)      state_nxt = S_EXT;
            else if (code == 8'hF0) state_nxt = S_BRK;
            else                    dec_make  = 1'b1;
          end
          S_EXT: begin
            if (code == 8'hF0)      state_nxt = S_EXT_BRK;
            else if (code != 8'hE0) begin
              dec_make  = 1'b1;
              dec_ext   = 1'b1;
              state_nxt = S_IDLE;
            end
          end
          S_BRK: begin
            if (code != 8'hE0 && code != 8'hF0) begin
              dec_brk   = 1'b1;
              state_nxt = S_IDLE;
            end
          end
          S_EXT_BRK: begin
            if (code != 8'hE0 && code != 8'hF0) begin
              dec_brk   = 1'b1;
              dec_ext   = 1'b1;
              state_nxt = S_IDLE;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  assign key = {dec_ext, code};

  // Parallel table lookup plus lowest-index free slot (downward scan, lowest wins)
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = int'(MAX_KEYS) - 1; i >= 0; i--) begin
      if (valid[i] && keys[i] == key) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // Event classification and next counter values
  always_comb begin
    new_press  = dec_make && !hit && free_ok;
    drop       = dec_make && !hit && !free_ok;
    brk_hit    = dec_brk && hit;
    held_nxt   = held_count;
    if (new_press)    held_nxt = held_count + HW'(1);
    else if (brk_hit) held_nxt = held_count - HW'(1);
    press_base = clear_count ? '0 : press_count;
    press_nxt  = press_base;
    if (new_press && press_base != '1) press_nxt = press_base + CNT_W'(1);
  end

  // Key table, event outputs and statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid       <= '0;
      for (int i = 0; i < int'(MAX_KEYS); i++) keys[i] <= '0;
      evt_valid   <= 1'b0;
      evt_code    <= '0;
      evt_make    <= 1'b0;
      evt_repeat  <= 1'b0;
      held_count  <= '0;
      any_held    <= 1'b0;
      last_key    <= '0;
      press_count <= '0;
      drop_err    <= 1'b0;
    end else begin
      evt_valid   <= 1'b0;
      held_count  <= held_nxt;
      any_held    <= (held_nxt != '0);
      press_count <= press_nxt;
      drop_err    <= (drop_err && !clear_count) || drop;
      if (dec_make && hit) begin
        evt_valid  <= 1'b1;
        evt_code   <= key;
        evt_make   <= 1'b1;
        evt_repeat <= 1'b1;
      end
      if (new_press) begin
        valid[free_idx] <= 1'b1;
        keys[free_idx]  <= key;
        last_key        <= key;
        evt_valid       <= 1'b1;
        evt_code        <= key;
        evt_make        <= 1'b1;
        evt_repeat      <= 1'b0;
      end
      if (brk_hit) begin
        valid[hit_idx] <= 1'b0;
        evt_valid      <= 1'b1;
        evt_code       <= key;
        evt_make       <= 1'b0;
        evt_repeat     <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised PS/2 Set-2 scan-code tracker between the PS/2 byte receiver and the keyboard display/logic. It decodes E0 (extended) and F0 (break) prefixes into make/break events. It keeps a table of up to MAX_KEYS simultaneously held keys, so typematic repeats are reported as repeats and are not counted as new presses. It also exports a saturating press counter, the last pressed key, and a held-key count.

## Interface
- MAX_KEYS, 4: held-key table depth; legal range 1..8.
- CNT_W, 8: width of press_count.
- HW, derived = $clog2(MAX_KEYS+1): width of held_count.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- code_valid  in  1  one-cycle strobe; code carries a new received byte.
- code  in  8  received scan byte.
- clear_count  in  1  synchronous clear of press_count and drop_err.
- evt_valid  out  1  one-cycle event pulse.
- evt_code  out  9  {ext, code} of the event key.
- evt_make  out  1  1 = make (press or repeat), 0 = break.
- evt_repeat  out  1  1 = make of a key already in the table.
- held_count  out  HW  number of valid table entries.
- any_held  out  1  held_count != 0.
- last_key  out  9  {ext, code} of the most recent new press.
- press_count  out  CNT_W  count of new presses; saturates at all-ones.
- drop_err  out  1  sticky; a new press was dropped because the table was full.

## Operation
- Reset values: FSM IDLE, all table valid bits 0, every output 0.
- Prefix FSM, advancing only on code_valid:
  - IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte is a make with ext=0.
  - EXT: F0 goes to EXT_BRK. E0 stays in EXT. Any other byte is a make with ext=1, then IDLE.
  - BRK / EXT_BRK: E0 and F0 are ignored and the state holds. Any other byte is a break with ext=0 / ext=1 respectively, then IDLE.
  - Bytes 00 and FF (receiver error/overrun) in any state return the FSM to IDLE with no event.
- Make of key K ({ext, code}), looked up in parallel against all valid table entries:
  - Hit: evt_valid=1, evt_make=1, evt_repeat=1. Table and counters unchanged.
  - Miss with a free slot: write K to the lowest-index free slot. held_count+1. press_count+1, saturating. last_key=K. Event make with evt_repeat=0.
  - Miss with table full: no event, no count change, drop_err=1.
- Break of key K:
  - Hit: invalidate that slot, held_count-1, evt_valid=1, evt_make=0, evt_repeat=0.
  - Miss (stray break): no event, no state change.
- Table entries are unique; one key never occupies two slots.
- clear_count together with a new press in the same cycle: press_count=1.
- clear_count together with a drop in the same cycle: drop_err=1.

## Timing
- Single clock domain. All outputs are registered.
- Latency: code_valid sampled at edge N gives evt_* valid for the cycle after edge N. held_count, press_count, last_key and drop_err update at the same edge N.
- evt_valid is exactly one cycle wide. evt_code, evt_make and evt_repeat hold their last value when evt_valid=0.
- Back-to-back code_valid on consecutive cycles is supported with no stall. Each byte is fully processed in its own cycle.
- Asynchronous reset mid-sequence (for example, after E0 F0) drops the partial prefix and clears the table immediately.
- Saturation: when press_count is all-ones, further new presses leave it all-ones. last_key still updates.

## Test plan
- Byte 1C, then F0 1C → make event 0x01C with evt_repeat=0, held_count=1, press_count=1, last_key=0x01C. Then a break event 0x01C, held_count=0, any_held=0.
- E0 75 ×3, then E0 F0 75 → make 0x175 with repeat=0, then two makes with repeat=1, then break 0x175. press_count=1 throughout.
- MAX_KEYS=4: makes 1C 1B 23 2B 34 → four events, held_count=4, fifth make dropped with no event, drop_err=1, press_count=4. Then clear_count → press_count=0, drop_err=0, held_count still 4.
- Stray break F0 1C with an empty table → no evt_valid, all counters unchanged. F0 E0 F0 1C → treated as a break of 0x01C (a miss here, so no event).
- CNT_W=2: four distinct make/break pairs → press_count sequence 1, 2, 3, 3. Send clear_count in the same cycle as a fifth make → press_count=1.
- Assert reset after E0 F0, then send 1C → press_count=0 after reset, and 1C is decoded as a make 0x01C (not an extended break).
